// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// uart_rx_if : receive-buffer read handshake and status pulses of uart_rx
// Revision   : 1.0
// ============================================================================
interface uart_rx_if;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  modport master (output rd_en, input rx_data, rx_valid, frame_err, overrun);
  modport slave  (input rd_en, output rx_data, rx_valid, frame_err, overrun);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx  : 8N1 UART receiver with a show-ahead receive buffer.
// Option   : UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO, else one holding register.
// Revision : 1.0
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx_pin,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitidx;
  logic [7:0]       shreg;
  logic             ferr;
  logic             ovr;
  logic             sync1;
  logic             rxs;
  logic             push;
  logic             pop;
  logic             store;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
    end
  end

  assign push = (state == STOP) && (cnt == LAST) && rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
      ferr   <= 1'b0;
    end else begin
      ferr <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt    <= '0;
            bitidx <= '0;
            state  <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt           <= '0;
            shreg[bitidx] <= rxs;
            if (bitidx == 3'd7) begin
              state <= STOP;
            end else begin
              bitidx <= bitidx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
          if (cnt == LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = bus.rd_en && (count != '0);
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign store = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      ovr <= push && !store;
      if (store) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      if (store && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !store) begin
        count <= count - CW'(1);
      end
    end
  end

  assign bus.rx_data  = mem[rd_ptr];
  assign bus.rx_valid = (count != '0);
`else
  logic [7:0] hold;
  logic       hold_valid;

  assign pop   = bus.rd_en && hold_valid;
  assign store = push && (!hold_valid || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      ovr <= push && !store;
      if (store) begin
        hold       <= shreg;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data  = hold;
  assign bus.rx_valid = hold_valid;
`endif

  assign bus.frame_err = ferr;
  assign bus.overrun   = ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : directed frames against a byte-queue model of the receiver.
// Revision   : 1.0
// ============================================================================
module tb_uart_rx;

  // Shortened bit period keeps the run short; the glitch stays under half a bit.
  localparam int CPB      = 260;
  localparam int HALF     = (CPB - 1) / 2;
  // Edge (counted from the cycle the start bit is driven) on which the stop bit is judged.
  localparam int STOP_OFS = 4 + HALF + 9 * CPB;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       stop;
  } ev_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rx_pin = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_pin (rx_pin),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         cyc       = 0;
  int         checks    = 0;
  int         errors    = 0;
  int         ferr_seen = 0;
  int         ovr_seen  = 0;
  bit         cmp_en    = 1'b0;
  logic       exp_ferr  = 1'b0;
  logic       exp_ovr   = 1'b0;
  ev_t        ev_q[$];
  ev_t        ev;
  logic [7:0] mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a byte queue that frames enter on their stop-bit edge.
  always @(posedge clk) begin
    cyc      = cyc + 1;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (rst) begin
      mq.delete();
      ev_q.delete();
    end else begin
      if (bus.rd_en && mq.size() > 0) void'(mq.pop_front());
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        ev = ev_q.pop_front();
        if (!ev.stop)                exp_ferr = 1'b1;
        else if (mq.size() < DEPTH)  mq.push_back(ev.data);
        else                         exp_ovr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rx_valid", bus.rx_valid, mq.size() != 0);
      if (mq.size() != 0) check("rx_data", bus.rx_data, mq[0]);
      check("frame_err", bus.frame_err, exp_ferr);
      check("overrun", bus.overrun, exp_ovr);
      if (bus.frame_err) ferr_seen++;
      if (bus.overrun)   ovr_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    ev_t e;
    e.cyc  = cyc + STOP_OFS;
    e.data = data;
    e.stop = stop;
    ev_q.push_back(e);
    rx_pin = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_pin = data[i];
      idle(CPB);
    end
    rx_pin = stop;
    idle(CPB);
  endtask

  task automatic read_byte(output logic [7:0] b);
    int n = 0;
    while (bus.rx_valid !== 1'b1 && n < 40 * CPB) begin
      idle(1);
      n++;
    end
    check("read_valid_wait", bus.rx_valid, 1);
    b          = bus.rx_data;
    bus.rd_en  = 1'b1;
    idle(1);
    bus.rd_en  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] v;
    int         p;

    bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_overrun", bus.overrun, 0);
    idle(20);

    // Back-to-back frames, read as they arrive.
    ferr_seen = 0; ovr_seen = 0;
    fork
      begin send_frame(8'h48, 1'b1); send_frame(8'h69, 1'b1); end
      begin
        read_byte(b); check("b2b_first", b, 8'h48);
        read_byte(b); check("b2b_second", b, 8'h69);
      end
    join
    idle(4);
    check("b2b_no_ferr", ferr_seen, 0);
    check("b2b_no_ovr", ovr_seen, 0);

    // Short low glitch on the idle line.
    rx_pin = 1'b0; idle(100); rx_pin = 1'b1; idle(2 * CPB);
    check("glitch_no_valid", bus.rx_valid, 0);
    fork
      send_frame(8'h55, 1'b1);
      read_byte(b);
    join
    check("after_glitch", b, 8'h55);

    // Bad stop bit, line held low, then a good frame.
    ferr_seen = 0;
    fork
      begin
        send_frame(8'hA5, 1'b0);
        idle(2 * CPB);
        rx_pin = 1'b1;
        idle(CPB);
        send_frame(8'h3C, 1'b1);
      end
      read_byte(b);
    join
    idle(4);
    check("ferr_next_byte", b, 8'h3C);
    check("ferr_pulses", ferr_seen, 1);

    // Five frames, no reads.
    ovr_seen = 0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(4);
    check("ovr_pulses", ovr_seen, 5 - DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      read_byte(b);
      check("ovr_read", b, 8'(i));
    end
    idle(2);
    check("ovr_drained", bus.rx_valid, 0);

    // Full buffer, pop on the very edge the next byte lands.
    ovr_seen = 0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1);
    idle(4);
    p = cyc + STOP_OFS;
    fork
      send_frame(8'h77, 1'b1);
      begin
        while (cyc < p - 1) idle(1);
        bus.rd_en = 1'b1;
        idle(1);
        bus.rd_en = 1'b0;
      end
    join
    idle(2);
    check("popwrite_no_ovr", ovr_seen, 0);
    for (int i = 0; i < DEPTH; i++) read_byte(b);
    check("popwrite_last", b, 8'h77);
    idle(2);
    check("popwrite_drained", bus.rx_valid, 0);

    // Reset during data bit 3 with a byte already buffered.
    send_frame(8'h5A, 1'b1);
    idle(2);
    check("prerst_valid", bus.rx_valid, 1);
    v = 8'h48;
    rx_pin = 1'b0; idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_pin = v[i];
      idle(CPB);
    end
    rx_pin = v[3];
    idle(CPB / 2);
    rst = 1'b1; idle(1); rst = 1'b0;
    rx_pin = 1'b1;
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun, 0);
    idle(12 * CPB);
    fork
      send_frame(8'h7E, 1'b1);
      read_byte(b);
    join
    check("post_rst_byte", b, 8'h7E);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
